// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS control FSM with memory-ready stalls
module multicycle_control #(
    parameter int ALUOP_WIDTH     = 3,
    parameter bit TRAP_ON_ILLEGAL = 1'b0,
    parameter int LINK_REG        = 31
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             OP,
    input  logic [5:0]             instructionFunct,
    input  logic                   mem_ready,
    output logic                   PCWrite,
    output logic                   PCWriteCondEQ,
    output logic                   PCWriteCondNE,
    output logic                   IorD,
    output logic                   MemRead,
    output logic                   MemWrite,
    output logic                   IRWrite,
    output logic                   RegDst,
    output logic                   MemtoReg,
    output logic                   RegWrite,
    output logic                   link,
    output logic                   ALUSrcA,
    output logic [1:0]             ALUSrcB,
    output logic [1:0]             PCSource,
    output logic [ALUOP_WIDTH-1:0] ALUOp,
    output logic                   instr_done,
    output logic                   illegal_op,
    output logic [3:0]             state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALU_WB_R = 4'd8,
        S_ALU_WB_I = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JR       = 4'd12,
        S_HALT     = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [ALUOP_WIDTH-1:0] ALU_SUB  = ALUOP_WIDTH'(3'b001);
    localparam logic [ALUOP_WIDTH-1:0] ALU_ADD  = ALUOP_WIDTH'(3'b010);
    localparam logic [ALUOP_WIDTH-1:0] ALU_LUI  = ALUOP_WIDTH'(3'b011);
    localparam logic [ALUOP_WIDTH-1:0] ALU_ADDI = ALUOP_WIDTH'(3'b100);
    localparam logic [ALUOP_WIDTH-1:0] ALU_ORI  = ALUOP_WIDTH'(3'b101);
    localparam logic [ALUOP_WIDTH-1:0] ALU_ANDI = ALUOP_WIDTH'(3'b110);
    localparam logic [ALUOP_WIDTH-1:0] ALU_RTYP = ALUOP_WIDTH'(3'b111);

    // A link write to r0 (or an out-of-range index) would be discarded, so it is suppressed.
    localparam bit LINK_ENABLE = (LINK_REG > 0) && (LINK_REG < 32);

    state_t state_q;
    state_t state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (OP)
                    OP_RTYPE:                         state_d = (instructionFunct == FN_JR) ? S_JR : S_EXEC_R;
                    OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
                    OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: state_d = S_EXEC_I;
                    OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
                    OP_J, OP_JAL:                     state_d = S_JUMP;
                    default:                          state_d = TRAP_ON_ILLEGAL ? S_HALT : S_FETCH;
                endcase
            end
            S_MEM_ADDR: state_d = (OP == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
            S_EXEC_R:   state_d = S_ALU_WB_R;
            S_EXEC_I:   state_d = S_ALU_WB_I;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        PCWrite       = 1'b0;
        PCWriteCondEQ = 1'b0;
        PCWriteCondNE = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        RegDst        = 1'b0;
        MemtoReg      = 1'b0;
        RegWrite      = 1'b0;
        link          = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        PCSource      = 2'b00;
        ALUOp         = '0;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                ALUOp   = ALU_ADD;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                ALUOp   = ALU_ADD;
                case (OP)
                    OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_ORI, OP_ANDI, OP_LUI,
                    OP_BEQ, OP_BNE, OP_J, OP_JAL: illegal_op = 1'b0;
                    default:                      illegal_op = 1'b1;
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = ALU_ADD;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_RTYP;
            end
            S_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                case (OP)
                    OP_ADDI: ALUOp = ALU_ADDI;
                    OP_ORI:  ALUOp = ALU_ORI;
                    OP_ANDI: ALUOp = ALU_ANDI;
                    OP_LUI:  ALUOp = ALU_LUI;
                    default: ALUOp = '0;
                endcase
            end
            S_ALU_WB_R: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
            end
            S_ALU_WB_I: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA       = 1'b1;
                ALUOp         = ALU_SUB;
                PCSource      = 2'b01;
                PCWriteCondEQ = (OP == OP_BEQ);
                PCWriteCondNE = (OP == OP_BNE);
                instr_done    = 1'b1;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                RegWrite   = LINK_ENABLE && (OP == OP_JAL);
                link       = LINK_ENABLE && (OP == OP_JAL);
                instr_done = 1'b1;
            end
            S_JR: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b11;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        // Reset must silence the datapath even though the state already reads FETCH.
        if (!reset) begin
            PCWrite       = 1'b0;
            PCWriteCondEQ = 1'b0;
            PCWriteCondNE = 1'b0;
            IorD          = 1'b0;
            MemRead       = 1'b0;
            MemWrite      = 1'b0;
            IRWrite       = 1'b0;
            RegDst        = 1'b0;
            MemtoReg      = 1'b0;
            RegWrite      = 1'b0;
            link          = 1'b0;
            ALUSrcA       = 1'b0;
            ALUSrcB       = 2'b00;
            PCSource      = 2'b00;
            ALUOp         = '0;
            instr_done    = 1'b0;
            illegal_op    = 1'b0;
        end
    end

    assign state = state_q;

endmodule
